// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register: widths, MIPS opcode
// constants used by hazard detection, and the stage FSM encoding.
package if_id_stage_pkg;

  localparam int unsigned ISA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OP_W      = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // RUN: normal operation; HAZ: one-cycle load-use hold already taken
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_HAZ = 1'b1
  } if_id_state_e;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detector for the instruction sitting in ID.
// Ports:
//   instr_hi    - bits [31:16] of the registered ID instruction (op, rs, rt)
//   id_valid    - ID instruction is real
//   ex_mem_read - instruction in EX is a load
//   ex_rt       - load destination register in EX
//   hazard      - ID reads the register the EX load is about to write
module if_id_stage_hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic [15:0]      instr_hi,
  input  logic             id_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             hazard
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             uses_rs;
  logic             uses_rt;

  assign op = instr_hi[15:10];
  assign rs = instr_hi[9:5];
  assign rt = instr_hi[4:0];

  // j/jal read no register; rt is a source only for R-type, branches and sw
  assign uses_rs = (op != OP_J) && (op != OP_JAL);
  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

  // $0 is never really written, so a load to it cannot create a dependence
  assign hazard = id_valid && ex_mem_read && (ex_rt != '0) &&
                  ((uses_rs && (ex_rt == rs)) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the MIPS core. Loads the fetched word and PC+4,
// holds on load-use hazards (one cycle) and external stalls, squashes on
// redirects, and keeps saturating stall/flush counters for debug.
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   if_instruction, if_pc_plus4   - fetch outputs
//   stall_in                      - external freeze request
//   flush                         - branch/jump/jr redirect this cycle
//   ex_mem_read, ex_rt            - load in EX and its destination
//   id_instruction, id_pc_plus4   - registered values to decode
//   id_valid, id_no_op            - ID slot holds a real instruction / a bubble
//   pc_hold, ex_bubble            - combinational controls to fetch and ID/EX
//   stall_count, flush_count      - saturating debug counters
module if_id_stage #(
  parameter int unsigned ISA_WIDTH = if_id_stage_pkg::ISA_WIDTH,
  parameter int unsigned CNT_WIDTH = if_id_stage_pkg::CNT_WIDTH,
  parameter logic [ISA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ISA_WIDTH-1:0] if_instruction,
  input  logic [ISA_WIDTH-1:0] if_pc_plus4,
  input  logic                 stall_in,
  input  logic                 flush,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rt,
  output logic [ISA_WIDTH-1:0] id_instruction,
  output logic [ISA_WIDTH-1:0] id_pc_plus4,
  output logic                 id_valid,
  output logic                 id_no_op,
  output logic                 pc_hold,
  output logic                 ex_bubble,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  import if_id_stage_pkg::*;

  if_id_state_e state;
  logic         hazard;
  logic         hazard_run;

  if_id_stage_hazard_detect u_hazard_detect (
    .instr_hi    (id_instruction[31:16]),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  // A hazard is acted on only in RUN; in HAZ the load has already moved to MEM
  assign hazard_run = hazard && (state == ST_RUN);

  // Flush wins so the redirect proceeds; a hazard also bubbles EX
  assign pc_hold   = !flush && (hazard_run || stall_in);
  assign ex_bubble = !flush && hazard_run;
  assign id_no_op  = ~id_valid;

  // Stage register, FSM and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_RUN;
      id_instruction <= NOP_WORD;
      id_pc_plus4    <= '0;
      id_valid       <= 1'b0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      if (flush) begin
        state          <= ST_RUN;
        id_instruction <= NOP_WORD;
        id_pc_plus4    <= if_pc_plus4;
        id_valid       <= 1'b0;
        if (flush_count != '1) flush_count <= flush_count + CNT_WIDTH'(1);
      end else if (hazard_run) begin
        state <= ST_HAZ;
        if (stall_count != '1) stall_count <= stall_count + CNT_WIDTH'(1);
      end else begin
        state <= ST_RUN;
        if (!stall_in) begin
          id_instruction <= if_instruction;
          id_pc_plus4    <= if_pc_plus4;
          id_valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed scenarios followed by random
// traffic; a reference model predicts every output each cycle.
module tb_if_id_stage;

  localparam int unsigned CW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   if_instruction = 32'h0;
  logic [31:0]   if_pc_plus4 = 32'h0;
  logic          stall_in = 1'b0;
  logic          flush = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [4:0]    ex_rt = 5'd0;
  logic [31:0]   id_instruction;
  logic [31:0]   id_pc_plus4;
  logic          id_valid;
  logic          id_no_op;
  logic          pc_hold;
  logic          ex_bubble;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  if_id_stage #(.ISA_WIDTH(32), .CNT_WIDTH(CW), .NOP_WORD(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_instruction (if_instruction),
    .if_pc_plus4    (if_pc_plus4),
    .stall_in       (stall_in),
    .flush          (flush),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .id_instruction (id_instruction),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid),
    .id_no_op       (id_no_op),
    .pc_hold        (pc_hold),
    .ex_bubble      (ex_bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic          valid;
    logic          pc_hold;
    logic          ex_bubble;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state: what decode should currently see
  logic [31:0]   m_instr = 32'h0;
  logic [31:0]   m_pc    = 32'h0;
  logic          m_valid = 1'b0;
  logic          m_held  = 1'b0;  // previous edge was a load-use hold
  logic [CW-1:0] m_scnt  = '0;
  logic [CW-1:0] m_fcnt  = '0;
  logic          m_init  = 1'b0;

  function automatic logic reads_dep(input logic [31:0] ins, input logic [4:0] dst);
    logic [5:0] op;
    op = ins[31:26];
    if (dst == 5'd0) return 1'b0;
    if (op != 6'h02 && op != 6'h03 && ins[25:21] == dst) return 1'b1;
    if ((op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B) && ins[20:16] == dst)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d got %h expected %h", name, c, got, want);
    end
  endtask

  // One clock of stimulus: drive inputs, predict, advance the model
  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                      input logic stl, input logic fl, input logic mr, input logic [4:0] rt);
    exp_t e;
    logic haz;
    @(negedge clock);
    reset = rst; if_instruction = ins; if_pc_plus4 = pc;
    stall_in = stl; flush = fl; ex_mem_read = mr; ex_rt = rt;
    haz = m_valid && mr && !m_held && reads_dep(m_instr, rt);
    if (m_init) begin
      e.cyc = cyc; e.instr = m_instr; e.pc = m_pc; e.valid = m_valid;
      e.pc_hold = !fl && (haz || stl);
      e.ex_bubble = !fl && haz;
      e.scnt = m_scnt; e.fcnt = m_fcnt;
      q.push_back(e);
    end
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_held = 1'b0;
      m_scnt = '0; m_fcnt = '0; m_init = 1'b1;
    end else if (fl) begin
      m_instr = 32'h0; m_pc = pc; m_valid = 1'b0; m_held = 1'b0;
      if (m_fcnt != {CW{1'b1}}) m_fcnt = m_fcnt + CW'(1);
    end else if (haz) begin
      m_held = 1'b1;
      if (m_scnt != {CW{1'b1}}) m_scnt = m_scnt + CW'(1);
    end else begin
      m_held = 1'b0;
      if (!stl) begin m_instr = ins; m_pc = pc; m_valid = 1'b1; end
    end
    cyc++;
  endtask

  // Monitor: compares every presented cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("id_instruction", e.cyc, id_instruction, e.instr);
        check("id_pc_plus4",    e.cyc, id_pc_plus4, e.pc);
        check("id_valid",       e.cyc, 32'(id_valid), 32'(e.valid));
        check("id_no_op",       e.cyc, 32'(id_no_op), 32'(!e.valid));
        check("pc_hold",        e.cyc, 32'(pc_hold), 32'(e.pc_hold));
        check("ex_bubble",      e.cyc, 32'(ex_bubble), 32'(e.ex_bubble));
        check("stall_count",    e.cyc, 32'(stall_count), 32'(e.scnt));
        check("flush_count",    e.cyc, 32'(flush_count), 32'(e.fcnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [8];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    // reset held three cycles with a live fetch word
    repeat (3) step(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 5'd0);
    // load-use: add $3,$2,$4 in ID while lw $2 in EX
    step(1'b0, 32'h0044_1820, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 5'd2);
    step(1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 5'd0);
    // rt of addi is a destination: no hazard
    step(1'b0, 32'h2044_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h0000_1820, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 5'd4);
    // add $3,$0,$0 against lw $0: exempt
    step(1'b0, 32'h0044_1820, 32'h0000_0018, 1'b0, 1'b0, 1'b1, 5'd0);
    // flush beats hazard and stall together
    step(1'b0, 32'h1111_1111, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 5'd2);
    // IO stall for five cycles
    step(1'b0, 32'h2008_0007, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (5) step(1'b0, 32'h2222_2222, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 5'd0);
    // stall and hazard together count as hazard
    step(1'b0, 32'h0044_1820, 32'h0000_010C, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h3333_3333, 32'h0000_0110, 1'b1, 1'b0, 1'b1, 5'd4);
    step(1'b0, 32'h3333_3333, 32'h0000_0110, 1'b1, 1'b0, 1'b1, 5'd4);
    step(1'b0, 32'h3333_3333, 32'h0000_0110, 1'b0, 1'b0, 1'b0, 5'd0);
    // reset arriving while the hold is in progress
    step(1'b0, 32'h0044_1820, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h4444_4444, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 5'd2);
    step(1'b1, 32'h4444_4444, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 5'd2);
    step(1'b0, 32'h0044_1820, 32'h0000_0208, 1'b0, 1'b0, 1'b0, 5'd0);
    // random traffic; small register set makes hazards frequent and both
    // counters reach saturation
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), rand_instr(), $urandom,
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
    end
    @(negedge clock);
    #5;
    check("scoreboard_drained", cyc, 32'(q.size()), 32'd0);
    check("stall_saturated", cyc, 32'(stall_count), 32'(m_scnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode for the MIPS core.
- Captures the fetched instruction and PC+4 each cycle and converts them into a valid/no-op pair for decode.
- Detects load-use hazards against the EX stage, holds the PC and this register, and injects a bubble into EX.
- Flushes on taken branch, jump or jr, and keeps saturating stall and flush counters for debug readout.

Parameters:
- ISA_WIDTH, 32, instruction and address width.
- CNT_WIDTH, 16, width of the stall and flush performance counters.
- NOP_WORD, 32'h0000_0000, word loaded into the register on a bubble (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- if_instruction  in  ISA_WIDTH  fetched instruction word.
- if_pc_plus4  in  ISA_WIDTH  PC+4 of the fetched instruction.
- stall_in  in  1  external hold, e.g. IO read waiting for confirm; freeze the register.
- flush  in  1  branch/jump/jr redirect resolved this cycle; discard the fetched word.
- ex_mem_read  in  1  instruction in EX is lw.
- ex_rt  in  5  destination register of the instruction in EX.
- id_instruction  out  ISA_WIDTH  registered instruction presented to decode.
- id_pc_plus4  out  ISA_WIDTH  registered PC+4, used as the branch base and link address.
- id_valid  out  1  id_instruction is a real instruction.
- id_no_op  out  1  equals ~id_valid; decode suppresses register writes and memory side effects.
- pc_hold  out  1  fetch must not advance the PC this cycle.
- ex_bubble  out  1  ID/EX register loads a NOP this cycle.
- stall_count  out  CNT_WIDTH  cycles in which pc_hold was 1 because of a hazard.
- flush_count  out  CNT_WIDTH  flushes accepted.

Behaviour:
- Reset values:
  - id_instruction = NOP_WORD, id_pc_plus4 = 0, id_valid = 0, id_no_op = 1.
  - pc_hold = 0, ex_bubble = 0, both counters = 0, FSM = RUN.
- Hazard detect, combinational on the registered ID instruction:
  - rs = id_instruction[25:21], rt = id_instruction[20:16], op = id_instruction[31:26].
  - uses_rs = (op != 6'h02 && op != 6'h03).
  - uses_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B).
  - hazard = id_valid && ex_mem_read && ex_rt != 0 && ((uses_rs && ex_rt == rs) || (uses_rt && ex_rt == rt)).
- FSM states: RUN, HAZ.
  - RUN -> HAZ when hazard && !flush. In that cycle the register holds, pc_hold = 1, ex_bubble = 1.
  - HAZ -> RUN unconditionally on the next edge, because the load has moved to MEM. Hazard is re-evaluated in RUN.
- Update priority at each rising edge, highest first:
  - reset.
  - flush: load NOP_WORD and valid = 0. id_pc_plus4 is loaded from if_pc_plus4. Flush overrides both stall_in and hazard; pc_hold = 0 so the redirect proceeds.
  - hazard (RUN only): hold the register.
  - stall_in: hold the register. pc_hold = 1, ex_bubble = 0. The counter does not increment.
  - otherwise: load if_instruction and if_pc_plus4, valid = 1.
- pc_hold and ex_bubble are combinational from the current state and inputs; zero latency to fetch.
- Load latency is one cycle: if_* sampled at edge N appears on id_* after edge N.
- stall_in and hazard together: hold, pc_hold = 1, ex_bubble = 1. stall_count increments, because the hazard is the cause.
- Counters saturate at all ones and never wrap.
  - stall_count increments once per hazard hold cycle.
  - flush_count increments once per edge where flush = 1.
- A reset asserted mid-HAZ returns the FSM to RUN with outputs at reset values on the same edge.

Decomposition:
- Shared definitions header holds:
  - ISA_WIDTH.
  - Opcode constants OP_RTYPE = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5, OP_SW = 6'h2B.
  - FSM state encodings.
- One sub-module, hazard_detect: purely combinational; produces hazard from the registered instruction, id_valid, ex_mem_read and ex_rt.
- Counters and the FSM live in the top block.

Test Plan:
- Reset: hold reset 3 cycles with if_instruction = 32'h2008_0005 -> id_instruction = 0, id_valid = 0, id_no_op = 1, counters 0. First edge after release loads 32'h2008_0005 with id_valid = 1.
- Load-use hazard:
  - Stimulus: ID holds add $3,$2,$4 (32'h0044_1820) with ex_mem_read = 1, ex_rt = 2.
  - Expect pc_hold = 1 and ex_bubble = 1 for exactly one cycle, then id_instruction unchanged, then normal load.
  - Expect stall_count = 1.
- rt false hazard: ex_rt = 4 with ID holding addi $4,$2,1 (32'h2044_0001, rt is a destination) -> no hazard, pc_hold = 0.
- $0 exemption: ex_rt = 0 with ex_mem_read = 1 and ID reading $0 -> no hazard.
- Flush priority:
  - Stimulus: flush = 1 in the same cycle as hazard and stall_in.
  - Expect id_instruction = 0, id_valid = 0, pc_hold = 0, flush_count incremented, stall_count unchanged.
- IO stall and saturation:
  - Stimulus: stall_in = 1 for 5 cycles.
  - Expect id_* frozen, pc_hold = 1, ex_bubble = 0, stall_count unchanged.
  - Force flush_count to 16'hFFFF and apply another flush: counter stays at 16'hFFFF.
